// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit: RV32I instruction fetch front end with a 2-entry instruction buffer
// Optional macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect halt)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  inst_opcode,
  output logic [2:0]  inst_func3,
  output logic        inst_30,
  output logic        fetch_misalign
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];

  logic [31:0] w_redirect_pc;
  logic        w_halted;
  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_redirect_pc  = redirect_pc;
  assign w_halted       = r_misalign;
  assign fetch_misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end
`else
  logic w_unused_redirect_lsbs;

  assign w_redirect_pc          = {redirect_pc[31:2], 2'b00};
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
  assign w_halted               = 1'b0;
  assign fetch_misalign         = 1'b0;
`endif

  // Requests are gated by reset so nothing is offered until the first released cycle.
  assign imem_req_valid = rst_n && (r_state == ST_IDLE) && (r_count != 2'd2)
                          && !w_halted && !redirect_valid;
  assign imem_req_addr  = {r_pc[31:2], 2'b00};
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid  = (r_count != 2'd0);
  assign inst        = inst_valid ? r_fifo_inst[r_rd_ptr] : C_NOP;
  assign inst_pc     = inst_valid ? r_fifo_pc[r_rd_ptr] : 32'h0000_0000;
  assign inst_opcode = inst[6:2];
  assign inst_func3  = inst[14:12];
  assign inst_30     = inst[30];

  assign w_push = (r_state == ST_WAIT_RSP) && imem_rsp_valid;
  assign w_pop  = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'h0000_0000;
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (redirect_valid) begin
      // Flush everything; a response landing this cycle belongs to the old path.
      r_pc     <= w_redirect_pc;
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      case (r_state)
        ST_WAIT_RSP: r_state <= imem_rsp_valid ? ST_IDLE : ST_DRAIN;
        ST_DRAIN:    r_state <= imem_rsp_valid ? ST_IDLE : ST_DRAIN;
        default:     r_state <= ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_state  <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (imem_rsp_valid) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (imem_rsp_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit: directed self-checking bench for fetch_unit (RESET_PC = 0x100)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [4:0]  inst_opcode;
  logic [2:0]  inst_func3;
  logic        inst_30;
  logic        fetch_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder state
  bit          pend;
  int          rem;
  int          lat;
  logic [31:0] pend_addr;
  bit          fire;
  logic [31:0] fire_addr;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_func3     (inst_func3),
    .inst_30        (inst_30),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h4000_5033 + a;
  endfunction

  // One clock cycle: sample the handshake, cross the edge, then present this cycle's response.
  task automatic tick();
    #1;
    fire      = imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      pend_addr = fire_addr;
      rem       = lat;
    end
    if (pend) begin
      if (rem <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        rem = rem - 1;
      end
    end
    #1;
  endtask

  task automatic reset_dut(input bit ir);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = ir;
    imem_req_ready = 1'b1;
    lat            = 1;
    tick();
    tick();
    pend           = 1'b0;
    imem_rsp_valid = 1'b0;
    rst_n          = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; lat = 1; pend = 1'b0;
    tick();
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
  endtask

  task automatic test_basic();
    reset_dut(1'b1);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_c0_valid: got %b expected 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL basic_c0_addr: got %h expected 00000100", imem_req_addr); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c1_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c1_inst_valid: got %b expected 0", inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_c2_inst_valid: got %b expected 1", inst_valid); end
    n_checks++; if (inst_pc !== 32'h100) begin n_fail++; $display("FAIL basic_c2_inst_pc: got %h expected 00000100", inst_pc); end
    n_checks++; if (inst !== 32'h4000_5133) begin n_fail++; $display("FAIL basic_c2_inst: got %h expected 40005133", inst); end
    n_checks++; if (inst_opcode !== 5'h0C) begin n_fail++; $display("FAIL basic_opcode: got %h expected 0c", inst_opcode); end
    n_checks++; if (inst_func3 !== 3'd5) begin n_fail++; $display("FAIL basic_func3: got %0d expected 5", inst_func3); end
    n_checks++; if (inst_30 !== 1'b1) begin n_fail++; $display("FAIL basic_inst_30: got %b expected 1", inst_30); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin n_fail++; $display("FAIL basic_c2_req: got %b/%h expected 1/00000104", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c3_inst_valid: got %b expected 0", inst_valid); end
    tick();
    n_checks++; if (inst_pc !== 32'h104 || inst !== 32'h4000_5137) begin n_fail++; $display("FAIL basic_c4_head: got %h/%h expected 00000104/40005137", inst_pc, inst); end
    n_checks++; if (imem_req_addr !== 32'h108) begin n_fail++; $display("FAIL basic_c4_addr: got %h expected 00000108", imem_req_addr); end
  endtask

  task automatic test_backpressure();
    reset_dut(1'b0);
    tick();
    tick();
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL bp_c4_head: got %b/%h expected 1/00000100", inst_valid, inst_pc); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_c4_req_valid: got %b expected 0", imem_req_valid); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b0 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL bp_c5_hold: got %b/%h expected 0/00000100", imem_req_valid, inst_pc); end
    inst_ready = 1'b1;
    tick();
    n_checks++; if (inst_pc !== 32'h104 || inst !== 32'h4000_5137) begin n_fail++; $display("FAIL bp_c6_head: got %h/%h expected 00000104/40005137", inst_pc, inst); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h108) begin n_fail++; $display("FAIL bp_c6_req: got %b/%h expected 1/00000108", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_req_stall();
    reset_dut(1'b1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL stall_c%0d_req: got %b/%h expected 1/00000100", i, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL stall_c3_req: got %b/%h expected 1/00000100", imem_req_valid, imem_req_addr); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_c4_valid: got %b expected 0", imem_req_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL stall_c5_head: got %b/%h expected 1/00000100", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_inflight();
    reset_dut(1'b1);
    lat = 2;
    tick();
    tick();
    tick();
    n_checks++; if (inst_pc !== 32'h100 || imem_req_addr !== 32'h104) begin n_fail++; $display("FAIL rdi_c3: got %h/%h expected 00000100/00000104", inst_pc, imem_req_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_c4_valid: got %b expected 0", imem_req_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_c5_drain: got %b/%b expected 0/0", inst_valid, imem_req_valid); end
    tick();
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rdi_c6_inst: got %h expected 00000013", inst); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rdi_c6_req: got %b/%h expected 1/00000200", imem_req_valid, imem_req_addr); end
    tick();
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h4000_5233) begin n_fail++; $display("FAIL rdi_c9_head: got %b/%h/%h expected 1/00000200/40005233", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_redirect_same_rsp();
    reset_dut(1'b0);
    tick();
    tick();
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL rds_c3_head: got %b/%h expected 1/00000100", inst_valid, inst_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rds_c4_flush: got %b/%h expected 0/00000013", inst_valid, inst); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rds_c4_req: got %b/%h expected 1/00000300", imem_req_valid, imem_req_addr); end
    inst_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (inst_pc !== 32'h300 || inst !== 32'h4000_5333) begin n_fail++; $display("FAIL rds_c6_head: got %h/%h expected 00000300/40005333", inst_pc, inst); end
  endtask

  task automatic test_wrap();
    reset_dut(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_c0_valid: got %b expected 0", imem_req_valid); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_c1_req: got %b/%h expected 1/fffffffc", imem_req_valid, imem_req_addr); end
    tick();
    tick();
    n_checks++; if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h4000_502F) begin n_fail++; $display("FAIL wrap_c3_head: got %h/%h expected fffffffc/4000502f", inst_pc, inst); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_c3_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_misalign();
    reset_dut(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++; if (fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", fetch_misalign); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_c1_valid: got %b expected 0", imem_req_valid); end
    tick();
    tick();
    n_checks++; if (imem_req_valid !== 1'b0 || fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_c3_halt: got %b/%b expected 0/1", imem_req_valid, fetch_misalign); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_reset_flag: got %b expected 0", fetch_misalign); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL mis_after_reset_req: got %b/%h expected 1/00000100", imem_req_valid, imem_req_addr); end
`else
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b expected 0", fetch_misalign); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL mis_c1_req: got %b/%h expected 1/00000200", imem_req_valid, imem_req_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_same_rsp();
    test_wrap();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
